// File: rtl/tx_byte_sequencer.sv
// Sequencer for an MSB-first parallel-to-serial shift register on the USB TX path.
// It holds one byte in a buffer and produces the load and shift strobes so bytes chain back-to-back.
module tx_byte_sequencer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int NUM_BITS     = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                byte_valid_i,
  input  logic [NUM_BITS-1:0] byte_data_i,
  input  logic                abort_i,
  output logic                byte_ready_o,
  output logic                load_enable_o,
  output logic                shift_enable_o,
  output logic [NUM_BITS-1:0] parallel_out_o,
  output logic                busy_o,
  output logic                byte_done_o
);

  localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic                hold_full_q, hold_full_d;
  logic [NUM_BITS-1:0] hold_data_q, hold_data_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      tmr_q       <= tmr_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  // Accept only depends on registered buffer state, so ready never combinationally follows valid.
  assign accept = byte_valid_i & ~hold_full_q;

  always_comb begin
    state_d        = state_q;
    hold_full_d    = hold_full_q;
    hold_data_d    = hold_data_q;
    tmr_d          = tmr_q;
    bit_cnt_d      = bit_cnt_q;
    load_enable_o  = 1'b0;
    shift_enable_o = 1'b0;
    byte_done_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) state_d = LOAD;
      end
      LOAD: begin
        load_enable_o = 1'b1;
        hold_full_d   = 1'b0;
        tmr_d         = '0;
        bit_cnt_d     = '0;
        state_d       = SHIFT;
      end
      SHIFT: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TMR_LAST) begin
          tmr_d = '0;
          if (bit_cnt_q < BIT_LAST) begin
            shift_enable_o = 1'b1;
            bit_cnt_d      = bit_cnt_q + BIT_W'(1);
          end else begin
            // Last bit period: reload straight from the buffer to avoid an idle gap.
            byte_done_o = 1'b1;
            bit_cnt_d   = '0;
            if (hold_full_q) begin
              load_enable_o = 1'b1;
              hold_full_d   = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load only happens with the buffer full and accept only with it empty, so these never collide.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = byte_data_i;
    end

    if (abort_i) begin
      state_d        = IDLE;
      hold_full_d    = 1'b0;
      hold_data_d    = hold_data_q;
      tmr_d          = '0;
      bit_cnt_d      = '0;
      load_enable_o  = 1'b0;
      shift_enable_o = 1'b0;
      byte_done_o    = 1'b0;
    end
  end

  assign byte_ready_o   = ~hold_full_q;
  assign busy_o         = (state_q != IDLE);
  assign parallel_out_o = hold_data_q;

endmodule
